// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, instruction register and req/ack
// fetch from program memory, stalling the micro-sequencer until a word lands.
module instr_fetch #(
  parameter int          ADDR_W      = 16,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic              i_nclk,
  input  logic              i_resetN,
  input  logic              i_ctrlInstrFinishedN,
  input  logic              i_ctrlMemPCLoadN,
  input  logic              i_ctrlMemPCFromImm,
  input  logic [ADDR_W-1:0] i_jumpAddr,
  output logic              o_pmemReq,
  output logic [ADDR_W-1:0] o_pmemAddr,
  input  logic              i_pmemAck,
  input  logic [15:0]       i_pmemData,
  output logic [7:0]        o_instrCode,
  output logic [7:0]        o_instrImm,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halt,
  output logic [1:0]        o_dbgState
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [7:0]        instrCode, instrCodeNext;
  logic [7:0]        instrImm, instrImmNext;

  always_ff @(posedge i_nclk or negedge i_resetN) begin
    if (!i_resetN) begin
      state     <= BOOT;
      pc        <= '0;
      instrCode <= '0;
      instrImm  <= '0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      instrCode <= instrCodeNext;
      instrImm  <= instrImmNext;
    end
  end

  // Handshake: o_pmemReq stays high with o_pmemAddr stable until an edge that
  // sees i_pmemAck high; that edge consumes i_pmemData. Ack without req is ignored.
  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    instrCodeNext = instrCode;
    instrImmNext  = instrImm;
    case (state)
      BOOT: stateNext = FETCH;
      FETCH: begin
        if (i_pmemAck) begin
          instrCodeNext = i_pmemData[15:8];
          instrImmNext  = i_pmemData[7:0];
          pcNext        = pc + ADDR_W'(1);
          stateNext     = (i_pmemData[15:8] == HALT_OPCODE) ? HALTED : EXEC;
        end
      end
      EXEC: begin
        if (!i_ctrlInstrFinishedN) begin
          stateNext = FETCH;
          // Page-relative jumps keep the upper bits of the already-incremented PC.
          if (!i_ctrlMemPCLoadN)
            pcNext = i_ctrlMemPCFromImm ? {pc[ADDR_W-1:8], instrImm} : i_jumpAddr;
        end
      end
      HALTED: stateNext = HALTED;
      default: stateNext = BOOT;
    endcase
  end

  assign o_pmemReq   = (state == FETCH);
  assign o_halt      = (state != EXEC);
  assign o_pmemAddr  = pc;
  assign o_pc        = pc;
  assign o_instrCode = instrCode;
  assign o_instrImm  = instrImm;
  assign o_dbgState  = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory responder driven from tasks,
// expected instruction words queued on ack and compared once latched.
module tb_instr_fetch;

  logic        i_nclk = 1'b0;
  logic        i_resetN = 1'b0;
  logic        i_ctrlInstrFinishedN = 1'b1;
  logic        i_ctrlMemPCLoadN = 1'b1;
  logic        i_ctrlMemPCFromImm = 1'b0;
  logic [15:0] i_jumpAddr = 16'h0;
  logic        o_pmemReq;
  logic [15:0] o_pmemAddr;
  logic        i_pmemAck = 1'b0;
  logic [15:0] i_pmemData = 16'h0;
  logic [7:0]  o_instrCode;
  logic [7:0]  o_instrImm;
  logic [15:0] o_pc;
  logic        o_halt;
  logic [1:0]  o_dbgState;

  instr_fetch dut (
    .i_nclk               (i_nclk),
    .i_resetN             (i_resetN),
    .i_ctrlInstrFinishedN (i_ctrlInstrFinishedN),
    .i_ctrlMemPCLoadN     (i_ctrlMemPCLoadN),
    .i_ctrlMemPCFromImm   (i_ctrlMemPCFromImm),
    .i_jumpAddr           (i_jumpAddr),
    .o_pmemReq            (o_pmemReq),
    .o_pmemAddr           (o_pmemAddr),
    .i_pmemAck            (i_pmemAck),
    .i_pmemData           (i_pmemData),
    .o_instrCode          (o_instrCode),
    .o_instrImm           (o_instrImm),
    .o_pc                 (o_pc),
    .o_halt               (o_halt),
    .o_dbgState           (o_dbgState)
  );

  // clock / watchdog
  always #5 i_nclk = ~i_nclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_q[$];
  logic [15:0] expPc = 16'h0;
  logic [7:0]  prevCode = 8'h0;
  logic [7:0]  prevImm = 8'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks (all input changes on the falling edge)
  task automatic apply_reset();
    @(negedge i_nclk);
    i_resetN = 1'b0;
    #1;
    check_eq("rst_req",   32'(o_pmemReq), 32'd0);
    check_eq("rst_halt",  32'(o_halt), 32'd1);
    check_eq("rst_pc",    32'(o_pc), 32'd0);
    check_eq("rst_code",  32'(o_instrCode), 32'd0);
    check_eq("rst_imm",   32'(o_instrImm), 32'd0);
    check_eq("rst_state", 32'(o_dbgState), 32'd0);
    @(negedge i_nclk);
    i_resetN = 1'b1;
    expPc = 16'h0;
    prevCode = 8'h0;
    prevImm = 8'h0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!o_pmemReq && n < 20) begin
      @(negedge i_nclk);
      n++;
    end
    ok = o_pmemReq;
    if (!ok) check_eq("req_timeout", 32'(o_pmemReq), 32'd1);
  endtask

  task automatic do_fetch(input logic [15:0] data, input int waits);
    bit ok;
    logic [15:0] e;
    wait_req(ok);
    if (!ok) return;
    check_eq("fetch_addr", 32'(o_pmemAddr), 32'(expPc));
    check_eq("fetch_halt", 32'(o_halt), 32'd1);
    for (int i = 0; i < waits; i++) begin
      @(negedge i_nclk);
      check_eq("wait_req",  32'(o_pmemReq), 32'd1);
      check_eq("wait_addr", 32'(o_pmemAddr), 32'(expPc));
      check_eq("wait_halt", 32'(o_halt), 32'd1);
      check_eq("wait_code", 32'({o_instrCode, o_instrImm}), 32'({prevCode, prevImm}));
    end
    i_pmemAck = 1'b1;
    i_pmemData = data;
    exp_q.push_back(data);
    @(negedge i_nclk);
    i_pmemAck = 1'b0;
    e = exp_q.pop_front();
    expPc = expPc + 16'd1;
    check_eq("lat_code", 32'(o_instrCode), 32'(e[15:8]));
    check_eq("lat_imm",  32'(o_instrImm), 32'(e[7:0]));
    check_eq("lat_pc",   32'(o_pc), 32'(expPc));
    check_eq("lat_halt", 32'(o_halt), (e[15:8] == 8'hFF) ? 32'd1 : 32'd0);
    check_eq("lat_req",  32'(o_pmemReq), 32'd0);
    prevCode = e[15:8];
    prevImm = e[7:0];
  endtask

  task automatic finish_instr(input logic loadN, input logic fromImm, input logic [15:0] jaddr);
    i_ctrlInstrFinishedN = 1'b0;
    i_ctrlMemPCLoadN = loadN;
    i_ctrlMemPCFromImm = fromImm;
    i_jumpAddr = jaddr;
    if (!loadN) expPc = fromImm ? {expPc[15:8], prevImm} : jaddr;
    @(negedge i_nclk);
    i_ctrlInstrFinishedN = 1'b1;
    i_ctrlMemPCLoadN = 1'b1;
    i_ctrlMemPCFromImm = 1'b0;
  endtask

  initial begin
    int reqSeen;
    int haltLow;
    bit ok;

    // reset then boot, zero wait states
    apply_reset();
    do_fetch(16'h1234, 0);

    // sequential fetch with three wait states
    finish_instr(1'b1, 1'b0, 16'h0);
    do_fetch(16'h5678, 3);

    // EXEC ignores ack and load/jump inputs while finish is high
    i_pmemAck = 1'b1;
    i_pmemData = 16'hAAAA;
    i_ctrlMemPCLoadN = 1'b0;
    i_jumpAddr = 16'h5555;
    repeat (3) @(negedge i_nclk);
    i_pmemAck = 1'b0;
    i_ctrlMemPCLoadN = 1'b1;
    check_eq("exec_hold_state", 32'(o_dbgState), 32'd2);
    check_eq("exec_hold_halt",  32'(o_halt), 32'd0);
    check_eq("exec_hold_pc",    32'(o_pc), 32'(expPc));
    check_eq("exec_hold_code",  32'({o_instrCode, o_instrImm}), 32'({prevCode, prevImm}));

    // absolute jump to top of memory, then fall through with wrap
    finish_instr(1'b0, 1'b0, 16'hFFFF);
    do_fetch(16'h0102, 0);
    finish_instr(1'b1, 1'b0, 16'h0);
    do_fetch(16'h0340, 1);

    // page-relative immediate jump: PC 0x0A11, imm 0x40 -> 0x0A40
    finish_instr(1'b0, 1'b0, 16'h0A10);
    do_fetch(16'h0340, 0);
    finish_instr(1'b0, 1'b1, 16'h7777);
    do_fetch(16'h0777, 0);
    finish_instr(1'b0, 1'b0, 16'h2000);
    do_fetch(16'h0800, 2);

    // a few random sequential fetches
    for (int k = 0; k < 4; k++) begin
      finish_instr(1'b1, 1'b0, 16'h0);
      do_fetch({8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))}, $urandom_range(0, 3));
    end

    // HALT opcode parks the block
    finish_instr(1'b1, 1'b0, 16'h0);
    do_fetch(16'hFF00, 0);
    reqSeen = 0;
    haltLow = 0;
    for (int k = 0; k < 50; k++) begin
      i_ctrlInstrFinishedN = 1'($urandom_range(0, 1));
      i_ctrlMemPCLoadN = 1'($urandom_range(0, 1));
      i_pmemAck = 1'($urandom_range(0, 1));
      i_pmemData = 16'h1234;
      @(negedge i_nclk);
      if (o_pmemReq) reqSeen++;
      if (!o_halt) haltLow++;
    end
    i_ctrlInstrFinishedN = 1'b1;
    i_ctrlMemPCLoadN = 1'b1;
    i_pmemAck = 1'b0;
    check_eq("halted_req_count",  32'(reqSeen), 32'd0);
    check_eq("halted_halt_low",   32'(haltLow), 32'd0);
    check_eq("halted_state",      32'(o_dbgState), 32'd3);
    check_eq("halted_code",       32'(o_instrCode), 32'hFF);
    check_eq("halted_pc",         32'(o_pc), 32'(expPc));

    // reset leaves HALTED and refetches from 0
    apply_reset();
    do_fetch(16'h1111, 0);

    // reset mid-fetch with ack arriving: request drops at once, late ack ignored
    finish_instr(1'b1, 1'b0, 16'h0);
    wait_req(ok);
    i_pmemAck = 1'b1;
    i_pmemData = 16'h9999;
    i_resetN = 1'b0;
    #1;
    check_eq("midrst_req",  32'(o_pmemReq), 32'd0);
    check_eq("midrst_pc",   32'(o_pc), 32'd0);
    check_eq("midrst_halt", 32'(o_halt), 32'd1);
    @(negedge i_nclk);
    i_resetN = 1'b1;
    @(negedge i_nclk);
    check_eq("lateack_state", 32'(o_dbgState), 32'd1);
    check_eq("lateack_pc",    32'(o_pc), 32'd0);
    check_eq("lateack_code",  32'({o_instrCode, o_instrImm}), 32'd0);
    check_eq("lateack_req",   32'(o_pmemReq), 32'd1);
    i_pmemAck = 1'b0;
    expPc = 16'h0;
    prevCode = 8'h0;
    prevImm = 8'h0;
    do_fetch(16'h2233, 0);

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
